// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-ported data memory, with bounded lock bursts.
// Optional build macro DMEM_ARB_RR_EN: round-robin contention (default is fixed priority to port A).
module dmem_arbiter #(
  parameter int DEPTH    = 1024,
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic        a_lock,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_we,
  input  logic        b_lock,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  output logic        b_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_dataW,
  output logic        mem_enaR,
  output logic        mem_enaW,
  input  logic [31:0] mem_data_out
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OWN_A = 2'd1;
  localparam logic [1:0] OWN_B = 2'd2;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  logic [1:0]    state_reg, state_next;
  logic          last_reg, last_next;
  logic [HW-1:0] hold_reg, hold_next;

  logic [1:0]  gnt;
  logic [1:0]  we_vec;
  logic [1:0]  in_rng;
  logic [31:0] addr_arr [2];

  logic        rvalid_reg [2];
  logic [31:0] rdata_reg  [2];
  logic        err_reg    [2];

  logic hold_a, hold_b;
  logic a_keeps, b_keeps, a_wins;

  assign addr_arr[0] = a_addr;
  assign addr_arr[1] = b_addr;
  assign we_vec      = {b_we, a_we};

  // Current owner still asking to keep the port.
  assign hold_a = (state_reg == OWN_A) && a_req && a_lock;
  assign hold_b = (state_reg == OWN_B) && b_req && b_lock;

  // A lock on B always yields to a waiting A once the hold budget is spent.
  assign b_keeps = !(a_req && (hold_reg == HOLD_MAX));

`ifdef DMEM_ARB_RR_EN
  assign a_wins  = (last_reg == PORT_B);
  assign a_keeps = !(b_req && (hold_reg == HOLD_MAX));
`else
  assign a_wins  = 1'b1;
  assign a_keeps = 1'b1;
`endif

  always_comb begin
    gnt = 2'b00;
    if (rst_n) begin
      if (hold_a) begin
        gnt[0] = a_keeps;
        gnt[1] = !a_keeps;
      end else if (hold_b) begin
        gnt[1] = b_keeps;
        gnt[0] = !b_keeps;
      end else if (a_req && b_req) begin
        gnt[0] = a_wins;
        gnt[1] = !a_wins;
      end else begin
        gnt[0] = a_req;
        gnt[1] = b_req;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    hold_next  = hold_reg;
    if (gnt[0]) begin
      state_next = a_lock ? OWN_A : IDLE;
      last_next  = PORT_A;
      if (last_reg != PORT_A)
        hold_next = '0;
      else if ((state_reg == OWN_A) && b_req && (hold_reg != HOLD_MAX))
        hold_next = hold_reg + 1'b1;
    end else if (gnt[1]) begin
      state_next = b_lock ? OWN_B : IDLE;
      last_next  = PORT_B;
      if (last_reg != PORT_B)
        hold_next = '0;
      else if ((state_reg == OWN_B) && a_req && (hold_reg != HOLD_MAX))
        hold_next = hold_reg + 1'b1;
    end
    if (state_next == IDLE)
      hold_next = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      last_reg  <= PORT_B;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      hold_reg  <= hold_next;
    end
  end

  // Per-port response path: range check and one-cycle read return.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign in_rng[gi] = addr_arr[gi] < 32'(DEPTH);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rvalid_reg[gi] <= 1'b0;
        rdata_reg[gi]  <= '0;
        err_reg[gi]    <= 1'b0;
      end else begin
        rvalid_reg[gi] <= gnt[gi] && !we_vec[gi];
        rdata_reg[gi]  <= (gnt[gi] && !we_vec[gi] && in_rng[gi]) ? mem_data_out : '0;
        err_reg[gi]    <= gnt[gi] && !in_rng[gi];
      end
    end
  end

  assign mem_addr  = gnt[0] ? a_addr  : (gnt[1] ? b_addr  : '0);
  assign mem_dataW = gnt[0] ? a_wdata : (gnt[1] ? b_wdata : '0);
  assign mem_enaW  = (gnt[0] && a_we && in_rng[0]) || (gnt[1] && b_we && in_rng[1]);
  assign mem_enaR  = (gnt[0] && !a_we && in_rng[0]) || (gnt[1] && !b_we && in_rng[1]);

  assign a_gnt = gnt[0];
  assign b_gnt = gnt[1];

  // Responses are forced quiet while reset is held, dropping any in-flight read.
  assign a_rvalid = rvalid_reg[0] && rst_n;
  assign a_rdata  = rst_n ? rdata_reg[0] : '0;
  assign a_err    = err_reg[0] && rst_n;
  assign b_rvalid = rvalid_reg[1] && rst_n;
  assign b_rdata  = rst_n ? rdata_reg[1] : '0;
  assign b_err    = err_reg[1] && rst_n;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1024-word memory (write on posedge, read on negedge).
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] mem_addr, mem_dataW, mem_data_out;
  logic        mem_enaR, mem_enaW;

  logic [31:0] mem [1024];
  int checks = 0;
  int errors = 0;
  int step_no = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_enaW) mem[mem_addr[9:0]] <= mem_dataW;
  always @(negedge clk) if (mem_enaR) mem_data_out <= mem[mem_addr[9:0]];

  dmem_arbiter #(.DEPTH(1024), .MAX_HOLD(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .mem_addr(mem_addr), .mem_dataW(mem_dataW), .mem_enaR(mem_enaR), .mem_enaW(mem_enaW),
    .mem_data_out(mem_data_out)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d got=%h expected=%h", tag, step_no, got, exp);
    end
  endtask

  // One bus cycle: drive after posedge, settle at negedge; registered outputs then show the previous cycle's response.
  task automatic step(input logic rs,
                      input logic ar, input logic aw, input logic al, input logic [31:0] aa, input logic [31:0] ad,
                      input logic br, input logic bw, input logic bl, input logic [31:0] ba, input logic [31:0] bd);
    @(posedge clk);
    #1;
    rst_n = rs;
    a_req = ar; a_we = aw; a_lock = al; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_lock = bl; b_addr = ba; b_wdata = bd;
    @(negedge clk);
    #1;
    step_no++;
    $display("step %0d rst_n=%b a_gnt=%b b_gnt=%b mem_addr=%0d enaR=%b enaW=%b a_rv=%b b_rv=%b",
             step_no, rst_n, a_gnt, b_gnt, mem_addr, mem_enaR, mem_enaW, a_rvalid, b_rvalid);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  logic [3:0] exp_a;

  initial begin
    rst_n = 1'b0;
    a_req = 0; a_we = 0; a_lock = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_lock = 0; b_addr = 0; b_wdata = 0;

    // Reset: requests are ignored and every output stays low.
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd0, 1'b1, 1'b0, 1'b0, 32'd7, 32'd0);
    check_val("rst_a_gnt", a_gnt, 0);
    check_val("rst_b_gnt", b_gnt, 0);
    check_val("rst_mem_enaR", mem_enaR, 0);
    check_val("rst_mem_addr", mem_addr, 0);
    check_val("rst_a_rvalid", a_rvalid, 0);
    check_val("rst_a_err", a_err, 0);

    // Write 5 and word 0, then read 5 back.
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'd5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check_val("wr_a_gnt", a_gnt, 1);
    check_val("wr_b_gnt", b_gnt, 0);
    check_val("wr_enaW", mem_enaW, 1);
    check_val("wr_enaR", mem_enaR, 0);
    check_val("wr_addr", mem_addr, 32'd5);
    check_val("wr_dataW", mem_dataW, 32'hDEADBEEF);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check_val("wr_no_rvalid", a_rvalid, 0);
    check_val("wr_no_err", a_err, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check_val("rd_a_gnt", a_gnt, 1);
    check_val("rd_enaR", mem_enaR, 1);
    check_val("rd_addr", mem_addr, 32'd5);
    idle();
    check_val("rd_rvalid", a_rvalid, 1);
    check_val("rd_rdata", a_rdata, 32'hDEADBEEF);
    check_val("idle_mem_addr", mem_addr, 0);
    check_val("idle_a_gnt", a_gnt, 0);

    // Out-of-range write is granted but never reaches memory.
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'd1024, 32'h1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check_val("rd_rvalid_once", a_rvalid, 0);
    check_val("oor_wr_gnt", a_gnt, 1);
    check_val("oor_wr_enaW", mem_enaW, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check_val("oor_wr_err", a_err, 1);
    check_val("oor_wr_rvalid", a_rvalid, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'd2000, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check_val("word0_kept", a_rdata, 32'h12345678);
    check_val("word0_rvalid", a_rvalid, 1);
    check_val("word0_err", a_err, 0);
    check_val("oor_rd_enaR", mem_enaR, 0);
    check_val("oor_rd_gnt", a_gnt, 1);
    idle();
    check_val("oor_rd_rvalid", a_rvalid, 1);
    check_val("oor_rd_rdata", a_rdata, 0);
    check_val("oor_rd_err", a_err, 1);

    // Contention with no locks; A was granted last, so round-robin starts with B.
    exp_a = RR ? 4'b1010 : 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'd5, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      check_val("cont_a_gnt", a_gnt, exp_a[i]);
      check_val("cont_b_gnt", b_gnt, !exp_a[i]);
      if (i > 0) begin
        check_val("cont_a_rvalid", a_rvalid, exp_a[i-1]);
        check_val("cont_b_rvalid", b_rvalid, !exp_a[i-1]);
      end
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    check_val("a_drop_b_gnt", b_gnt, 1);
    check_val("a_drop_a_gnt", a_gnt, 0);
    idle();
    check_val("b_rd_rvalid", b_rvalid, 1);
    check_val("b_rd_rdata", b_rdata, 32'h12345678);

    // B lock burst against a waiting A: 8 contended grants to B, A on the 9th.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd5, 32'd0);
    check_val("blk_first", b_gnt, 1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd5, 32'd0);
      check_val("blk_b_gnt", b_gnt, 1);
      check_val("blk_a_gnt", a_gnt, 0);
      check_val("blk_b_rdata", b_rdata, 32'hDEADBEEF);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd5, 32'd0);
    check_val("blk_preempt_a", a_gnt, 1);
    check_val("blk_preempt_b", b_gnt, 0);
    check_val("blk_preempt_addr", mem_addr, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd5, 32'd0);
    check_val("after_preempt_a", a_gnt, !RR);
    check_val("after_preempt_rdata", a_rdata, 32'h12345678);
    idle();

    // A lock burst against B: fixed priority never yields, round-robin yields on the 9th.
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check_val("alk_first", a_gnt, 1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, 32'd5, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      check_val("alk_a_gnt", a_gnt, 1);
      check_val("alk_b_gnt", b_gnt, 0);
    end
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'd5, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    check_val("alk_ninth_a", a_gnt, !RR);
    check_val("alk_ninth_b", b_gnt, RR);
    idle();

    // Reset in the middle of a B burst, right after a B read grant.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd5, 32'd0);
    check_val("mid_b_gnt", b_gnt, 1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd5, 32'd0);
    check_val("mid_rst_a_gnt", a_gnt, 0);
    check_val("mid_rst_b_gnt", b_gnt, 0);
    check_val("mid_rst_enaR", mem_enaR, 0);
    check_val("mid_rst_addr", mem_addr, 0);
    check_val("mid_rst_b_rvalid", b_rvalid, 0);
    check_val("mid_rst_b_rdata", b_rdata, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd5, 32'd0);
    check_val("post_rst_a_gnt", a_gnt, 1);
    check_val("post_rst_b_gnt", b_gnt, 0);
    check_val("post_rst_b_rvalid", b_rvalid, 0);
    idle();
    check_val("post_rst_a_rvalid", a_rvalid, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
